// File: rtl/multicycle_seq_if.sv
// Sequencer <-> core/memory bundle: fetch handshake, control inputs, PC/strobe outputs.
// instret member exists only when INSTRET_EN is defined.
interface multicycle_seq_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic            fetch_req;
  logic            fetch_ack;
  logic [XLEN-1:0] inst_in;
  logic [XLEN-1:0] inst_out;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            halt;
  logic [XLEN-1:0] pc;
  logic            wb_en;
  logic            pc_upd;
  logic [1:0]      state;
  logic            halted;
`ifdef INSTRET_EN
  logic [CNT_W-1:0] instret;
`endif

  modport master (
`ifdef INSTRET_EN
    output instret,
`endif
    output fetch_req, inst_out, pc, wb_en, pc_upd, state, halted,
    input  fetch_ack, inst_in, stall, redirect_valid, redirect_target, halt
  );

  modport slave (
`ifdef INSTRET_EN
    input  instret,
`endif
    input  fetch_req, inst_out, pc, wb_en, pc_upd, state, halted,
    output fetch_ack, inst_in, stall, redirect_valid, redirect_target, halt
  );
endinterface

// File: rtl/multicycle_seq.sv
// FETCH -> EXEC(EXEC_CYCLES, stallable) -> WB sequencer owning the PC; min EXEC_CYCLES+2 cycles/instr,
// fetch waits on fetch_ack, EXEC freezes on stall. INSTRET_EN adds a retired-instruction counter.
module multicycle_seq #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
  parameter int              PC_INC       = 4,
  parameter int              EXEC_CYCLES  = 1,
  parameter int              CNT_W        = 64
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_seq_if.master   bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_inst, w_inst_nxt;
  logic            w_fetch_req;
  logic            w_wb;
  logic            w_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_pc    <= RESET_VECTOR;
      r_inst  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_fetch_req = 1'b0;
    w_wb        = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_fetch_req = 1'b1;
        if (bus.fetch_ack) begin
          w_inst_nxt  = bus.inst_in;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!bus.stall) begin
          if (r_cnt == 4'd0) w_state_nxt = S_WB;
          else               w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      S_WB: begin
        w_wb = 1'b1;
        // Redirect targets are halfword-aligned at minimum; bit 0 never reaches the PC.
        w_pc_nxt    = bus.redirect_valid ? {bus.redirect_target[XLEN-1:1], 1'b0}
                                         : r_pc + XLEN'(PC_INC);
        w_state_nxt = bus.halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  assign bus.fetch_req = w_fetch_req;
  assign bus.wb_en     = w_wb;
  assign bus.pc_upd    = w_wb;
  assign bus.halted    = w_halted;
  assign bus.pc        = r_pc;
  assign bus.inst_out  = r_inst;
  assign bus.state     = r_state;

`ifdef INSTRET_EN
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_instret <= '0;
    else if (r_state == S_WB) r_instret <= r_instret + CNT_W'(1);
  end

  assign bus.instret = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// Randomized bench for multicycle_seq: two instances (EXEC_CYCLES=3 at 0x80000000, EXEC_CYCLES=1 at 0xFFFFFFFC)
// checked against a per-instruction transaction model.
module tb_multicycle_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_ack = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] inst_in = '0;
  logic [31:0] redirect_target = '0;
  bit          sel = 1'b0;

  int          n_chk = 0;
  int          n_err = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  longint      m_ret;
  int          exec_n;
  logic [31:0] rv;

  always #5 clk = ~clk;

  multicycle_seq_if #(.XLEN(32), .CNT_W(64)) ifa ();
  multicycle_seq_if #(.XLEN(32), .CNT_W(64)) ifb ();

  assign ifa.fetch_ack       = fetch_ack;
  assign ifa.inst_in         = inst_in;
  assign ifa.stall           = stall;
  assign ifa.redirect_valid  = redirect_valid;
  assign ifa.redirect_target = redirect_target;
  assign ifa.halt            = halt;
  assign ifb.fetch_ack       = fetch_ack;
  assign ifb.inst_in         = inst_in;
  assign ifb.stall           = stall;
  assign ifb.redirect_valid  = redirect_valid;
  assign ifb.redirect_target = redirect_target;
  assign ifb.halt            = halt;

  multicycle_seq #(.EXEC_CYCLES(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  multicycle_seq #(.RESET_VECTOR(32'hFFFF_FFFC), .EXEC_CYCLES(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  wire [31:0] o_pc        = sel ? ifb.pc        : ifa.pc;
  wire [31:0] o_inst      = sel ? ifb.inst_out  : ifa.inst_out;
  wire [1:0]  o_state     = sel ? ifb.state     : ifa.state;
  wire        o_fetch_req = sel ? ifb.fetch_req : ifa.fetch_req;
  wire        o_wb_en     = sel ? ifb.wb_en     : ifa.wb_en;
  wire        o_pc_upd    = sel ? ifb.pc_upd    : ifa.pc_upd;
  wire        o_halted    = sel ? ifb.halted    : ifa.halted;
`ifdef INSTRET_EN
  wire [63:0] o_instret   = sel ? ifb.instret   : ifa.instret;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_strobes(input string tag, input logic [1:0] st);
    check({tag, ".state"},     64'(o_state),     64'(st));
    check({tag, ".fetch_req"}, 64'(o_fetch_req), 64'(st == 2'd0));
    check({tag, ".wb_en"},     64'(o_wb_en),     64'(st == 2'd2));
    check({tag, ".pc_upd"},    64'(o_pc_upd),    64'(st == 2'd2));
    check({tag, ".halted"},    64'(o_halted),    64'(st == 2'd3));
    check({tag, ".pc"},        64'(o_pc),        64'(m_pc));
    check({tag, ".inst_out"},  64'(o_inst),      64'(m_inst));
`ifdef INSTRET_EN
    check({tag, ".instret"},   o_instret,        64'(m_ret));
`endif
  endtask

  // Asserts reset away from any clock edge so the outputs must already show reset values.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_pc   = rv;
    m_inst = '0;
    m_ret  = 0;
    check_strobes("reset", 2'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full instruction starting at a negedge where the DUT sits in FETCH.
  // EXEC needs exec_n unstalled cycles; stall is forced low after stall_max cycles.
  task automatic run_instr(input int dly, input int stall_pct, input int stall_max,
                           input logic redir, input logic [31:0] tgt, input logic hlt,
                           input logic [31:0] ins);
    int n;
    int guard;
    check_strobes("fetch", 2'd0);
    repeat (dly) begin
      fetch_ack = 1'b0;
      stall     = 1'($urandom_range(0, 1));
      inst_in   = $urandom;
      @(negedge clk);
      check_strobes("fetch_wait", 2'd0);
    end
    fetch_ack = 1'b1;
    inst_in   = ins;
    stall     = 1'($urandom_range(0, 1));
    @(negedge clk);
    m_inst = ins;
    n      = 0;
    guard  = 0;
    while (n < exec_n) begin
      check_strobes("exec", 2'd1);
      stall     = (guard < stall_max) && (int'($urandom_range(0, 99)) < stall_pct);
      fetch_ack = 1'($urandom_range(0, 1));
      inst_in   = $urandom;
      guard++;
      if (!stall) n++;
      @(negedge clk);
    end
    check_strobes("wb", 2'd2);
    redirect_valid  = redir;
    redirect_target = tgt;
    halt            = hlt;
    stall           = 1'($urandom_range(0, 1));
    fetch_ack       = 1'($urandom_range(0, 1));
    inst_in         = $urandom;
    @(negedge clk);
    m_pc  = redir ? (tgt & 32'hFFFF_FFFE) : (m_pc + 32'd4);
    m_ret = m_ret + 1;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    if (hlt) begin
      repeat (3) begin
        check_strobes("halt", 2'd3);
        fetch_ack = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    // Instance A: EXEC_CYCLES=3, reset vector 0x80000000.
    sel    = 1'b0;
    exec_n = 3;
    rv     = 32'h8000_0000;
    do_reset();
    run_instr(5, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0050_0093);
    check("ack_low_pc", 64'(o_pc), 64'h8000_0004);
    run_instr(0, 0, 0, 1'b1, 32'h8000_0101, 1'b0, $urandom);
    check("redirect_pc", 64'(o_pc), 64'h8000_0100);
    run_instr(0, 100, 4, 1'b0, 32'h0, 1'b0, $urandom);
    for (int i = 0; i < 20; i++) begin
      run_instr($urandom_range(0, 3), 40, 16, ($urandom_range(0, 3) == 0),
                $urandom, 1'b0, $urandom);
    end
    run_instr(0, 0, 0, 1'b1, 32'h8000_0010, 1'b0, $urandom);
    run_instr(1, 30, 8, 1'b0, 32'h0, 1'b1, $urandom);
    check("halt_pc", 64'(o_pc), 64'h8000_0014);
    do_reset();
    // Abort mid-EXEC: reset must discard the accepted instruction.
    fetch_ack = 1'b1;
    inst_in   = 32'hDEAD_BEEF;
    @(negedge clk);
    fetch_ack = 1'b0;
    do_reset();

    // Instance B: EXEC_CYCLES=1, reset vector near the top of the address space.
    sel    = 1'b1;
    exec_n = 1;
    rv     = 32'hFFFF_FFFC;
    do_reset();
    run_instr(0, 0, 0, 1'b0, 32'h0, 1'b0, $urandom);
    check("wrap_pc0", 64'(o_pc), 64'h0000_0000);
    run_instr(0, 0, 0, 1'b0, 32'h0, 1'b0, $urandom);
    check("wrap_pc1", 64'(o_pc), 64'h0000_0004);
    run_instr(0, 0, 0, 1'b0, 32'h0, 1'b0, $urandom);
`ifdef INSTRET_EN
    check("instret3", o_instret, 64'd3);
`endif
    for (int i = 0; i < 20; i++) begin
      run_instr($urandom_range(0, 2), 30, 8, ($urandom_range(0, 2) == 0),
                $urandom, 1'b0, $urandom);
    end
    run_instr(0, 0, 0, 1'b0, 32'h0, 1'b1, $urandom);
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Parametrised successor to the fixed 3-phase clock-count/PC pair in the rv32 core.
- Sequences each instruction through FETCH -> EXEC(N cycles) -> WB and owns the PC register.
- Adds an instruction-fetch handshake, execute stall, branch/jump redirect, halt, and a configurable execute depth.
- Drives the register-file write strobe and PC-update strobe that replace clk1_flag and clk2_flag.

Parameters:
XLEN, 32, PC and instruction width.
RESET_VECTOR, 32'h8000_0000, PC value after reset; width XLEN.
PC_INC, 4, sequential PC increment.
EXEC_CYCLES, 1, cycles spent in EXEC when not stalled; legal range 1..16.
CNT_W, 64, width of the optional retire counter.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
fetch_req  output  1  instruction fetch request; high only in FETCH
fetch_ack  input  1  inst_in valid this cycle; sampled only in FETCH
inst_in  input  XLEN  instruction from memory
inst_out  output  XLEN  latched instruction, held stable from EXEC through WB
stall  input  1  freeze EXEC progress
redirect_valid  input  1  take redirect_target at WB
redirect_target  input  XLEN  next PC on redirect
halt  input  1  stop after the current WB
pc  output  XLEN  current instruction PC
wb_en  output  1  register-file write strobe, one cycle in WB
pc_upd  output  1  PC update strobe, one cycle in WB
state  output  2  FETCH=0, EXEC=1, WB=2, HALT=3
halted  output  1  high in HALT
instret  output  CNT_W  retired count; present only with INSTRET_EN

Behaviour:
- Reset (async, immediate) clears all state:
  - state=FETCH, pc=RESET_VECTOR, inst_out=0.
  - Execute counter=0, instret=0.
  - wb_en=pc_upd=halted=0; fetch_req=1 while in FETCH.
- Reset asserted mid-operation aborts the instruction. No WB strobe occurs and no partial PC update occurs.
- fetch_req, wb_en, pc_upd and halted are decoded combinationally from the state register only.
- FETCH:
  - fetch_ack=0: remain in FETCH; pc and inst_out hold.
  - fetch_ack=1: inst_out<=inst_in, counter<=EXEC_CYCLES-1, go to EXEC.
  - stall is ignored in FETCH.
- EXEC:
  - stall=1: hold state and counter.
  - Else if counter==0: go to WB.
  - Else: counter decrements.
- WB lasts exactly one cycle. wb_en=pc_upd=1. stall is ignored.
- PC update at the WB clock edge:
  - redirect_valid=1: pc<=redirect_target with bit 0 forced to 0.
  - Else: pc<=pc+PC_INC, truncated to XLEN bits; wraps modulo 2^XLEN.
- Next state from WB:
  - halt=1: go to HALT; the PC update still happens.
  - Else: go to FETCH.
  - halt and redirect_valid both high: both take effect.
- HALT is terminal until reset. All strobes are 0, halted=1, pc holds.
- Minimum latency per instruction is EXEC_CYCLES+2 cycles (fetch_ack high on the FETCH cycle, no stall). With EXEC_CYCLES=1 this is 3 cycles, matching the legacy core.
- inst_out changes only on an accepted fetch.

Optional Feature:
- Macro: INSTRET_EN.
- Defined: instret port exists. It increments by 1 at the end of every WB cycle, wraps at 2^CNT_W, and is cleared by rst.
- Undefined: instret port and counter are absent; no other behaviour changes.

Test Plan:
- Reset release, fetch_ack tied 1, EXEC_CYCLES=1 -> pc=0x80000000. pc_upd pulses every 3rd cycle and pc steps 0x80000004, 0x80000008. state sequence 0,1,2,0.
- fetch_ack held 0 for 5 cycles, then 1 with inst_in=0x00500093 -> state stays 0 and pc is unchanged for 5 cycles. inst_out=0x00500093 on the next cycle.
- redirect_valid=1 with target=0x80000101 during WB -> pc=0x80000100 after that edge. Next fetch_req issues at 0x80000100.
- EXEC_CYCLES=3 with stall high for 4 cycles in EXEC -> WB reached 7 cycles after fetch accept. Exactly one wb_en pulse.
- halt=1 in WB at pc=0x80000010 -> pc=0x80000014, halted=1, fetch_req=0 indefinitely. Async rst then gives pc=0x80000000 and state=0 immediately without a clock edge.
- RESET_VECTOR=0xFFFFFFFC, INSTRET_EN defined, 3 instructions -> pc wraps to 0x00000000 then 0x00000004; instret=3.
